// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: bridges single CPU load/store requests to either a
// wait-state data memory (addresses below 0x2000) or one of five
// memory-mapped devices that complete with devAck. Misaligned,
// unmapped, read-only-store and timed-out accesses finish with busErr.
module io_bus_ctrl #(
    parameter int          MEM_WAIT  = 1,
    parameter int          TIMEOUT   = 15,
    parameter logic [31:0] ADDR_HEX  = 32'hF0000000,
    parameter logic [31:0] ADDR_LEDR = 32'hF0000004,
    parameter logic [31:0] ADDR_LEDG = 32'hF0000008,
    parameter logic [31:0] ADDR_KEY  = 32'hF0000010,
    parameter logic [31:0] ADDR_SW   = 32'hF0000014
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWdata,
    output logic [31:0] cpuRdata,
    output logic        cpuReady,
    output logic        cpuStall,
    output logic        busErr,
    output logic [10:0] memAddr,
    output logic        memWe,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    output logic [4:0]  devSel,
    output logic        devWe,
    output logic [31:0] devWdata,
    input  logic [31:0] devRdata,
    input  logic        devAck
);

    typedef enum logic [2:0] {IDLE, MEM, DEV, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [10:0] maddr_q, maddr_d;   // held word index addr[12:2]
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  sel_q, sel_d;       // held one-hot device select
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  wait_q, wait_d;     // MEM cycle counter
    logic [7:0]  tmo_q, tmo_d;       // DEV cycle counter

    // Device address table, index 0 = HEX ... index 4 = SW
    logic [4:0][31:0] dev_addr;
    logic [4:0]       dev_hit;
    logic             ro_hit;

    assign dev_addr = {ADDR_SW, ADDR_KEY, ADDR_LEDG, ADDR_LEDR, ADDR_HEX};

    // Compare the live request address against every device slot
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dev_dec
            assign dev_hit[gi] = (cpuAddr == dev_addr[gi]);
        end
    endgenerate

    // KEY and SW are read-only
    assign ro_hit = dev_hit[3] | dev_hit[4];

    // State and holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            maddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state decode, request latching, counters and read-data capture
    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                tmo_d  = '0;
                if (cpuReq) begin
                    maddr_d = cpuAddr[12:2];
                    we_d    = cpuWe;
                    wdata_d = cpuWdata;
                    rdata_d = '0;
                    sel_d   = '0;
                    if (cpuAddr[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else if (cpuAddr < 32'h2000) begin
                        state_d = MEM;
                    end else if ((|dev_hit) && !(cpuWe && ro_hit)) begin
                        state_d = DEV;
                        sel_d   = dev_hit;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            MEM: begin
                if (wait_q == 3'(MEM_WAIT - 1)) begin
                    if (!we_q) begin
                        rdata_d = memRdata;
                    end
                    wait_d  = '0;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            DEV: begin
                // An acknowledge in the final allowed cycle still wins
                if (devAck) begin
                    if (!we_q) begin
                        rdata_d = devRdata;
                    end
                    state_d = DONE;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registered state so reset clears them at once
    always_comb begin
        cpuReady = (state_q == DONE) || (state_q == ERR);
        busErr   = (state_q == ERR);
        cpuRdata = (state_q == DONE) ? rdata_q : 32'h0;
        cpuStall = ((state_q == IDLE) && cpuReq) || (state_q == MEM) || (state_q == DEV);
        memAddr  = maddr_q;
        memWdata = wdata_q;
        memWe    = (state_q == MEM) && we_q && (wait_q == 3'd0);
        devWdata = wdata_q;
        devSel   = (state_q == DEV) ? sel_q : 5'b0;
        devWe    = (state_q == DEV) && we_q && (tmo_q == 8'd0);
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Testbench for io_bus_ctrl: two instances (MEM_WAIT=1/TIMEOUT=15 and
// MEM_WAIT=3/TIMEOUT=4) share stimulus; 'sel' picks which one is driven.
module tb_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpuReq = 1'b0;
    logic        cpuWe = 1'b0;
    logic [31:0] cpuAddr = '0;
    logic [31:0] cpuWdata = '0;
    logic [31:0] memRdata = '0;
    logic [31:0] devRdata = '0;
    logic        devAck = 1'b0;
    logic        sel = 1'b0;
    logic        req_a, req_b;

    logic [31:0] a_rdata, b_rdata, o_rdata;
    logic        a_ready, b_ready, o_ready;
    logic        a_stall, b_stall, o_stall;
    logic        a_err, b_err, o_err;
    logic [10:0] a_maddr, b_maddr, o_maddr;
    logic        a_mwe, b_mwe, o_mwe;
    logic [31:0] a_mwd, b_mwd, o_mwd;
    logic [4:0]  a_dsel, b_dsel, o_dsel;
    logic        a_dwe, b_dwe, o_dwe;
    logic [31:0] a_dwd, b_dwd, o_dwd;

    int nvec = 0;
    int nerr = 0;

    bit [31:0] devs [5] = '{32'hF0000000, 32'hF0000004, 32'hF0000008,
                            32'hF0000010, 32'hF0000014};

    always #5 clk = ~clk;

    assign req_a = sel ? 1'b0 : cpuReq;
    assign req_b = sel ? cpuReq : 1'b0;

    io_bus_ctrl #(.MEM_WAIT(1), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst), .cpuReq(req_a), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
        .cpuWdata(cpuWdata), .cpuRdata(a_rdata), .cpuReady(a_ready),
        .cpuStall(a_stall), .busErr(a_err), .memAddr(a_maddr), .memWe(a_mwe),
        .memWdata(a_mwd), .memRdata(memRdata), .devSel(a_dsel), .devWe(a_dwe),
        .devWdata(a_dwd), .devRdata(devRdata), .devAck(devAck)
    );

    io_bus_ctrl #(.MEM_WAIT(3), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .cpuReq(req_b), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
        .cpuWdata(cpuWdata), .cpuRdata(b_rdata), .cpuReady(b_ready),
        .cpuStall(b_stall), .busErr(b_err), .memAddr(b_maddr), .memWe(b_mwe),
        .memWdata(b_mwd), .memRdata(memRdata), .devSel(b_dsel), .devWe(b_dwe),
        .devWdata(b_dwd), .devRdata(devRdata), .devAck(devAck)
    );

    always_comb begin
        o_rdata = sel ? b_rdata : a_rdata;
        o_ready = sel ? b_ready : a_ready;
        o_stall = sel ? b_stall : a_stall;
        o_err   = sel ? b_err   : a_err;
        o_maddr = sel ? b_maddr : a_maddr;
        o_mwe   = sel ? b_mwe   : a_mwe;
        o_mwd   = sel ? b_mwd   : a_mwd;
        o_dsel  = sel ? b_dsel  : a_dsel;
        o_dwe   = sel ? b_dwe   : a_dwe;
        o_dwd   = sel ? b_dwd   : a_dwd;
    end

    // Reference classification: 0 = memory, 1 = device, 2 = error
    function automatic int classify(input bit [31:0] addr, input bit we, output int idx);
        idx = -1;
        if (addr % 4 != 0) return 2;
        if (addr < 32'h2000) return 0;
        for (int i = 0; i < 5; i++) if (addr == devs[i]) idx = i;
        if (idx < 0) return 2;
        if (we && idx >= 3) return 2;
        return 1;
    endfunction

    // Drive one access starting in an IDLE cycle (cycle 0) and check every cycle
    task automatic run_txn(input bit [31:0] addr, input bit we, input bit [31:0] wd,
                           input int ack_k, input bit keep, input string tag);
        int mw, to, kind, idx, lat;
        bit tmo;
        bit [31:0] mrd, drd, exp_rd;
        bit [4:0] exp_sel;
        mw   = sel ? 3 : 1;
        to   = sel ? 4 : 15;
        kind = classify(addr, we, idx);
        tmo  = (kind == 1) && !(ack_k >= 1 && ack_k <= to);
        if (kind == 0)      lat = mw + 1;
        else if (kind == 2) lat = 1;
        else if (tmo)       lat = to + 1;
        else                lat = ack_k + 1;
        mrd = $urandom;
        drd = $urandom;
        exp_sel = (kind == 1) ? (5'b1 << idx) : 5'b0;
        if (kind == 2 || tmo || we) exp_rd = 0;
        else if (kind == 0)          exp_rd = mrd;
        else                         exp_rd = drd;
        cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wd;
        for (int c = 0; c <= lat; c++) begin
            if (c >= 1) begin
                cpuAddr = $urandom; cpuWdata = $urandom; cpuWe = 1'($urandom_range(0, 1));
            end
            memRdata = (c == mw) ? mrd : $urandom;
            devRdata = (c == ack_k) ? drd : $urandom;
            devAck   = (kind == 1 && c >= 1) ? (c == ack_k) : 1'($urandom_range(0, 1));
            @(negedge clk);
            nvec++;
            if (o_stall !== (c < lat)) begin
                nerr++; $display("FAIL %s stall c=%0d got=%b exp=%b", tag, c, o_stall, (c < lat));
            end
            nvec++;
            if (o_ready !== (c == lat)) begin
                nerr++; $display("FAIL %s ready c=%0d got=%b exp=%b", tag, c, o_ready, (c == lat));
            end
            nvec++;
            if (o_err !== (c == lat && (kind == 2 || tmo))) begin
                nerr++; $display("FAIL %s busErr c=%0d got=%b", tag, c, o_err);
            end
            nvec++;
            if (o_mwe !== (kind == 0 && we && c == 1)) begin
                nerr++; $display("FAIL %s memWe c=%0d got=%b", tag, c, o_mwe);
            end
            nvec++;
            if (o_dwe !== (kind == 1 && we && c == 1)) begin
                nerr++; $display("FAIL %s devWe c=%0d got=%b", tag, c, o_dwe);
            end
            nvec++;
            if (o_dsel !== ((kind == 1 && c >= 1 && c < lat) ? exp_sel : 5'b0)) begin
                nerr++; $display("FAIL %s devSel c=%0d got=%b exp=%b", tag, c, o_dsel, exp_sel);
            end
            if (c == lat) begin
                nvec++;
                if (o_rdata !== exp_rd) begin
                    nerr++; $display("FAIL %s rdata got=%h exp=%h", tag, o_rdata, exp_rd);
                end
            end
            if (kind == 0 && c >= 1 && c < lat) begin
                nvec++;
                if (o_maddr !== addr[12:2]) begin
                    nerr++; $display("FAIL %s memAddr got=%0d exp=%0d", tag, o_maddr, addr[12:2]);
                end
                if (we) begin
                    nvec++;
                    if (o_mwd !== wd) begin
                        nerr++; $display("FAIL %s memWdata got=%h exp=%h", tag, o_mwd, wd);
                    end
                end
            end
            if (kind == 1 && we && c == 1) begin
                nvec++;
                if (o_dwd !== wd) begin
                    nerr++; $display("FAIL %s devWdata got=%h exp=%h", tag, o_dwd, wd);
                end
            end
            @(posedge clk); #1;
        end
        if (!keep) begin
            cpuReq = 1'b0; devAck = 1'b0;
            @(negedge clk);
            nvec++;
            if ({o_stall, o_ready, o_err, o_mwe, o_dwe, o_dsel} !== 10'b0) begin
                nerr++; $display("FAIL %s post-idle got=%b%b%b%b%b dsel=%b", tag,
                                 o_stall, o_ready, o_err, o_mwe, o_dwe, o_dsel);
            end
            @(posedge clk); #1;
        end
        $display("txn %-10s dut=%0d addr=%h we=%0d ack=%0d lat=%0d", tag, sel, addr, we, ack_k, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; cpuReq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nvec++;
            if ({o_ready, o_err, o_mwe, o_dwe, o_dsel, o_stall} !== 10'b0) begin
                nerr++; $display("FAIL reset ctrl dut=%0d got=%b%b%b%b dsel=%b", s, o_ready, o_err, o_mwe, o_dwe, o_dsel);
            end
            nvec++;
            if ({o_rdata, o_maddr, o_mwd, o_dwd} !== 107'b0) begin
                nerr++; $display("FAIL reset data dut=%0d rd=%h ma=%h wd=%h", s, o_rdata, o_maddr, o_mwd);
            end
        end
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_mem();
        sel = 1'b0;
        run_txn(32'h40, 1'b1, 32'hCAFEF00D, 0, 1'b0, "mem_st");
        run_txn(32'h40, 1'b0, 32'h0, 0, 1'b0, "mem_ld");
        run_txn(32'h1FFC, 1'b0, 32'h0, 0, 1'b0, "mem_top");
        run_txn(32'h2000, 1'b0, 32'h0, 0, 1'b0, "mem_edge");
    endtask

    task automatic test_dev();
        sel = 1'b0;
        run_txn(32'hF0000004, 1'b1, 32'h3FF, 3, 1'b0, "ledr_st");
        run_txn(32'hF0000010, 1'b0, 32'h0, 1, 1'b0, "key_ld");
        run_txn(32'hF0000000, 1'b1, 32'h7F, 15, 1'b0, "hex_last");
    endtask

    task automatic test_errors();
        sel = 1'b0;
        run_txn(32'hF0000014, 1'b1, 32'h1, 2, 1'b0, "sw_st");
        run_txn(32'hF0000010, 1'b1, 32'h1, 2, 1'b0, "key_st");
        run_txn(32'h42, 1'b0, 32'h0, 0, 1'b0, "misalign");
        run_txn(32'hF000000C, 1'b0, 32'h0, 1, 1'b0, "unmapped");
        run_txn(32'hF0000010, 1'b0, 32'h0, 0, 1'b0, "timeout");
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        run_txn(32'h100, 1'b1, 32'h12345678, 0, 1'b1, "b2b_st");
        run_txn(32'h100, 1'b0, 32'h0, 0, 1'b1, "b2b_ld");
        run_txn(32'hF0000008, 1'b1, 32'hAA, 2, 1'b1, "b2b_dev");
        run_txn(32'h3, 1'b0, 32'h0, 0, 1'b0, "b2b_err");
    endtask

    task automatic test_reset_abort();
        sel = 1'b1;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 32'h80; cpuWdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        @(negedge clk);
        nvec++;
        if (o_mwe !== 1'b1) begin
            nerr++; $display("FAIL abort memWe-pre got=%b exp=1", o_mwe);
        end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if (o_mwe !== 1'b0 || o_ready !== 1'b0) begin
            nerr++; $display("FAIL abort memWe-drop got we=%b rdy=%b exp=0", o_mwe, o_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        nvec++;
        if (o_ready !== 1'b0 || o_err !== 1'b0) begin
            nerr++; $display("FAIL abort ready got=%b err=%b exp=0", o_ready, o_err);
        end
        rst = 1'b0;
        run_txn(32'h80, 1'b1, 32'h5A5A5A5A, 0, 1'b0, "restart");
    endtask

    task automatic test_random();
        bit [31:0] a;
        int r, to;
        for (int n = 0; n < 60; n++) begin
            sel = 1'($urandom_range(0, 1));
            to  = sel ? 4 : 15;
            r   = $urandom_range(0, 5);
            case (r)
                0:       a = {19'b0, 11'($urandom_range(0, 2047)), 2'b00};
                1:       a = {19'b0, 11'($urandom_range(0, 2047)), 2'($urandom_range(1, 3))};
                2, 3:    a = devs[$urandom_range(0, 4)];
                4:       a = {$urandom} & 32'hFFFFFFFC;
                default: a = $urandom_range(0, 1) ? 32'h1FFC : 32'h2000;
            endcase
            run_txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, to + 2),
                    1'($urandom_range(0, 1)), "random");
        end
        cpuReq = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mem();
        test_dev();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MEM_WAIT, 1, data-memory read latency in cycles (1..7)
- TIMEOUT, 15, maximum cycles to wait for devAck (1..255)
- ADDR_HEX / ADDR_LEDR / ADDR_LEDG / ADDR_KEY / ADDR_SW, 32'hF0000000 / 32'hF0000004 / 32'hF0000008 / 32'hF0000010 / 32'hF0000014, device word addresses
REQ-002 There SHALL be one clock; reset is asynchronous and active-high. Ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- cpuReq  in  1  access request, held until cpuReady
- cpuWe  in  1  1 = store, 0 = load
- cpuAddr  in  32  byte address
- cpuWdata  in  32  store data
- cpuRdata  out  32  load data, valid while cpuReady=1
- cpuReady  out  1  one-cycle completion pulse
- cpuStall  out  1  freeze CPU pipeline
- busErr  out  1  one-cycle error pulse, coincident with cpuReady
- memAddr  out  11  data-memory word index (held addr[12:2])
- memWe  out  1  data-memory write strobe
- memWdata  out  32  data-memory write data
- memRdata  in  32  data-memory read data
- devSel  out  5  one-hot {SW,KEY,LEDG,LEDR,HEX}, bit0=HEX
- devWe  out  1  device write strobe
- devWdata  out  32  device write data
- devRdata  in  32  selected device read data
- devAck  in  1  device completion

Function
REQ-003 FSM states SHALL be IDLE, MEM, DEV, DONE, ERR.
REQ-004 In IDLE with cpuReq=1, cpuAddr, cpuWe, and cpuWdata SHALL be latched into holding registers; all later outputs SHALL use the held values only.
REQ-005 The IDLE decode SHALL select the next state as follows, in priority order.
- addr[1:0]!=0 -> ERR
- addr<32'h2000 -> MEM
- addr equals a device address -> DEV
- any other address -> ERR
REQ-006 A store to ADDR_KEY or ADDR_SW (read-only devices) SHALL go to ERR; the device SHALL not be selected.
REQ-007 MEM SHALL last exactly MEM_WAIT cycles, counted by a 3-bit wait counter. For a store, memWe SHALL be 1 only in the first MEM cycle. For a load, memRdata SHALL be captured into cpuRdata on the last MEM cycle. MEM SHALL then go to DONE.
REQ-008 In DEV, devSel SHALL be held one-hot for the decoded device. devWe SHALL be 1 only in the first DEV cycle, for a store.
- devAck=1: DEV SHALL go to DONE; for a load, devRdata SHALL be captured that cycle.
- devAck absent for TIMEOUT DEV cycles (8-bit counter): DEV SHALL go to ERR.
REQ-009 DONE SHALL last one cycle with cpuReady=1, then go to IDLE. cpuRdata SHALL be 0 for stores.
REQ-010 ERR SHALL last one cycle with cpuReady=1, busErr=1, and cpuRdata=0, then go to IDLE. No memory or device write SHALL occur for an errored access.
REQ-011 cpuStall SHALL be 1 when (state==IDLE and cpuReq=1) or state is MEM or DEV, and 0 otherwise (combinational).
REQ-012 cpuReq SHALL be sampled only in IDLE. A request still high in the DONE/ERR cycle SHALL be ignored; a new access SHALL start no earlier than the following IDLE cycle.
REQ-013 Latency from the cpuReq sample cycle (cycle 0) to cpuReady SHALL be:
- memory access: cycle MEM_WAIT+1
- device access: cycle k+1, where devAck arrives in cycle k
- decode error: cycle 1
- timeout: cycle TIMEOUT+1
REQ-014 devAck outside DEV SHALL be ignored. memWe and devWe SHALL never both be 1.

Reset
REQ-015 While rst=1, state SHALL be IDLE. cpuRdata, cpuReady, busErr, memWe, devWe, devSel, both counters, and the holding registers SHALL be 0.
REQ-016 rst asserted mid-access SHALL abort the access with no cpuReady and no further strobes. After release, the FSM SHALL resume in IDLE and re-sample cpuReq.

Verification
REQ-017 Memory store/load, MEM_WAIT=1.
- Store 32'hCAFEF00D to 32'h40: memAddr=16 and memWe=1 in cycle 1, cpuReady in cycle 2.
- Load 32'h40 with memRdata=32'hCAFEF00D: cpuRdata=32'hCAFEF00D with cpuReady in cycle 2.
REQ-018 LEDR store 32'h3FF, devAck in cycle 3 -> devSel=5'b00010 in cycles 1-3, devWe=1 in cycle 1 only, cpuReady in cycle 4, cpuStall=1 in cycles 0-3.
REQ-019 Error cases.
- Store to ADDR_SW -> busErr=cpuReady=1 in cycle 1, devSel=0 throughout.
- Load 32'h42 -> busErr=cpuReady=1 in cycle 1, cpuRdata=0.
REQ-020 KEY load with devAck never asserted, TIMEOUT=15 -> busErr=cpuReady=1 in cycle 16, devSel=0 in cycle 17.
REQ-021 Reset in cycle 1 of a memory store with MEM_WAIT=3 -> memWe drops immediately, no cpuReady. After release with cpuReq high, the access restarts and completes normally.
